// File: rtl/ulpi_rx_framer.sv
// ULPI receive framer: turns RX CMD activity and received bytes into FIFO entries
// tagged with start/end/error of packet, presented first-word-fall-through.
module ulpi_rx_framer #(
  parameter int DEPTH = 16
) (
  input  logic        ulpi_clk,
  input  logic        sys_reset,
  input  logic [7:0]  sys_data,
  input  logic        sys_data_valid,
  input  logic [7:0]  sys_rx_cmd,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  line_state,
  output logic        ovf,
  output logic [15:0] pkt_cnt
);

  // state  | meaning
  // IDLE   | no packet in progress; received bytes are ignored
  // ACTIVE | packet in progress; bytes pass through the holding register
  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam int AW = $clog2(DEPTH);

  state_t      state, state_nxt;
  logic [7:0]  held_byte;
  logic        held_sop;
  logic        held_valid;
  logic        err_flag;

  logic [10:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic [10:0] head_word;

  logic        rx_active, rx_error;
  logic        wr_req, wr_eop, wr_err;
  logic        hold_load, hold_clear;
  logic        err_set, err_clr, pkt_inc;
  logic        pop, wr_ok, wr_drop;
  logic [10:0] wr_word;
  logic        unused_rx_cmd;

  assign unused_rx_cmd = ^{sys_rx_cmd[7:6], sys_rx_cmd[3:2]};
  assign rx_active = sys_rx_cmd[4];
  assign rx_error  = sys_rx_cmd[5] & sys_rx_cmd[4];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && out_ready;
  assign wr_ok      = wr_req && (!fifo_full || pop);
  assign wr_drop    = wr_req && fifo_full && !pop;
  assign wr_word    = {wr_err, wr_eop, held_sop, held_byte};

  always_comb begin
    state_nxt  = state;
    wr_req     = 1'b0;
    wr_eop     = 1'b0;
    wr_err     = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    pkt_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_active) begin
          state_nxt = S_ACTIVE;
          err_clr   = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (!rx_active) begin
          state_nxt = S_IDLE;
          // Only now is the held byte known to be the last one of the packet.
          if (held_valid) begin
            wr_req     = 1'b1;
            wr_eop     = 1'b1;
            wr_err     = err_flag;
            hold_clear = 1'b1;
            pkt_inc    = 1'b1;
          end
        end else begin
          err_set = rx_error;
          if (sys_data_valid) begin
            hold_load = 1'b1;
            wr_req    = held_valid;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ulpi_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state      <= S_IDLE;
      held_byte  <= '0;
      held_sop   <= 1'b0;
      held_valid <= 1'b0;
      err_flag   <= 1'b0;
      ovf        <= 1'b0;
      pkt_cnt    <= '0;
      line_state <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_nxt;
      line_state <= sys_rx_cmd[1:0];
      if (hold_load) begin
        held_byte  <= sys_data;
        held_sop   <= !held_valid;
        held_valid <= 1'b1;
      end else if (hold_clear) begin
        held_valid <= 1'b0;
      end
      if (err_clr)
        err_flag <= 1'b0;
      else if (err_set || wr_drop)
        err_flag <= 1'b1;
      if (wr_drop)
        ovf <= 1'b1;
      if (pkt_inc)
        pkt_cnt <= pkt_cnt + 16'd1;
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge ulpi_clk) begin
    if (wr_ok)
      mem[wr_ptr[AW-1:0]] <= wr_word;
  end

  assign head_word = fifo_empty ? 11'd0 : mem[rd_ptr[AW-1:0]];
  assign out_data  = head_word[7:0];
  assign out_sop   = head_word[8];
  assign out_eop   = head_word[9];
  assign out_err   = head_word[10];
  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_ulpi_rx_framer.sv
// Scoreboard bench for ulpi_rx_framer: expected FIFO entries are queued as packets
// are driven and compared whenever the consumer accepts a head entry.
module tb_ulpi_rx_framer;
  localparam int DEPTH = 4;

  logic        ulpi_clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic [7:0]  sys_data = '0;
  logic        sys_data_valid = 1'b0;
  logic [7:0]  sys_rx_cmd = '0;
  logic [7:0]  out_data;
  logic        out_sop, out_eop, out_err, out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  line_state;
  logic        ovf;
  logic [15:0] pkt_cnt;

  int          n_chk = 0;
  int          n_pass = 0;
  int          exp_pkt = 0;
  logic [10:0] exp_q[$];
  logic [10:0] exp_word;

  always #5 ulpi_clk = ~ulpi_clk;

  ulpi_rx_framer #(.DEPTH(DEPTH)) dut (
    .ulpi_clk       (ulpi_clk),
    .sys_reset      (sys_reset),
    .sys_data       (sys_data),
    .sys_data_valid (sys_data_valid),
    .sys_rx_cmd     (sys_rx_cmd),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_err        (out_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .line_state     (line_state),
    .ovf            (ovf),
    .pkt_cnt        (pkt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge ulpi_clk);
      #1;
    end
  endtask

  task automatic expect_entry(input logic [7:0] b, input logic sop, input logic eop, input logic err);
    exp_q.push_back({err, eop, sop, b});
  endtask

  task automatic start_pkt();
    sys_rx_cmd = 8'h10;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    sys_data = b;
    sys_data_valid = 1'b1;
    step();
    sys_data_valid = 1'b0;
  endtask

  task automatic end_pkt();
    sys_rx_cmd = 8'h00;
    step();
  endtask

  task automatic drain(input string tag);
    int k;
    out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 40) begin
      step();
      k++;
    end
    check(tag, exp_q.size(), 0);
    check({tag, "_empty"}, out_valid, 0);
  endtask

  // Consumer side: compare every accepted head against the oldest expectation.
  always @(negedge ulpi_clk) begin
    if (!sys_reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_valid, 0);
      end else begin
        exp_word = exp_q.pop_front();
        check("head", {21'd0, out_err, out_eop, out_sop, out_data}, {21'd0, exp_word});
      end
    end
  end

  initial begin
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_head", {out_err, out_eop, out_sop, out_data}, 0);
    check("rst_ovf", ovf, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_line_state", line_state, 0);
    step(2);
    sys_reset = 1'b0;
    step();

    // Line state follows RX CMD; bytes while idle are ignored.
    sys_rx_cmd = 8'h02;
    step();
    check("line_state", line_state, 2);
    send_byte(8'hEE);
    step();
    check("idle_byte_ignored", out_valid, 0);

    // Basic three-byte packet.
    out_ready = 1'b1;
    expect_entry(8'hA5, 1, 0, 0);
    expect_entry(8'h5A, 0, 0, 0);
    expect_entry(8'hC3, 0, 1, 0);
    start_pkt();
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'hC3);
    end_pkt();
    drain("pkt1_drain");
    exp_pkt = 1;
    check("pkt1_cnt", pkt_cnt, exp_pkt);

    // RxError mid-packet marks the eop entry.
    expect_entry(8'h11, 1, 0, 0);
    expect_entry(8'h22, 0, 1, 1);
    start_pkt();
    send_byte(8'h11);
    sys_rx_cmd = 8'h30;
    step();
    send_byte(8'h22);
    end_pkt();
    drain("pkt2_drain");
    exp_pkt = 2;
    check("pkt2_cnt", pkt_cnt, exp_pkt);

    // Zero-byte packet.
    start_pkt();
    end_pkt();
    step(3);
    check("empty_pkt_valid", out_valid, 0);
    check("empty_pkt_cnt", pkt_cnt, exp_pkt);

    // Single byte; head appears the cycle after the exit edge writes it.
    out_ready = 1'b0;
    expect_entry(8'h7E, 1, 1, 0);
    start_pkt();
    send_byte(8'h7E);
    check("single_pre_valid", out_valid, 0);
    end_pkt();
    check("single_fwft", out_valid, 1);
    drain("single_drain");
    exp_pkt = 3;
    check("single_cnt", pkt_cnt, exp_pkt);

    // Overflow: six bytes into four slots, consumer stalled.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      expect_entry(8'(i), i == 1, 0, 0);
    start_pkt();
    for (int i = 1; i <= 6; i++)
      send_byte(8'(i));
    end_pkt();
    step();
    check("ovf_set", ovf, 1);
    check("ovf_cnt", pkt_cnt, exp_pkt + 1);
    for (int i = 0; i < 3; i++) begin
      check("stall_hold", {out_valid, out_sop, out_data}, {1'b1, 1'b1, 8'h01});
      step();
    end
    drain("ovf_drain");
    exp_pkt = 4;

    // Reset mid-packet discards it.
    out_ready = 1'b0;
    start_pkt();
    send_byte(8'h31);
    send_byte(8'h32);
    sys_reset = 1'b1;
    sys_rx_cmd = 8'h00;
    #2;
    check("midrst_valid", out_valid, 0);
    step();
    sys_reset = 1'b0;
    step();
    exp_pkt = 0;
    check("midrst_cnt", pkt_cnt, exp_pkt);
    check("midrst_ovf", ovf, 0);
    out_ready = 1'b1;
    expect_entry(8'h41, 1, 0, 0);
    expect_entry(8'h42, 0, 1, 0);
    start_pkt();
    send_byte(8'h41);
    send_byte(8'h42);
    end_pkt();
    drain("postrst_drain");
    exp_pkt = 1;
    check("postrst_cnt", pkt_cnt, exp_pkt);

    // Write and pop on the same edge while full: nothing dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      expect_entry(8'h21 + 8'(i), i == 0, i == 5, 0);
    start_pkt();
    for (int i = 0; i < 5; i++)
      send_byte(8'h21 + 8'(i));
    out_ready = 1'b1;
    send_byte(8'h26);
    end_pkt();
    drain("full_pop_drain");
    exp_pkt = 2;
    check("full_pop_ovf", ovf, 0);
    check("full_pop_cnt", pkt_cnt, exp_pkt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ulpi_rx_framer.md
ULPI_RX_FRAMER -- requirements
Module: ulpi_rx_framer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count (power of 2, 4..256).
REQ-002 SHALL have port ulpi_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port sys_data  input  8  received byte from ULPI link stage.
REQ-005 SHALL have port sys_data_valid  input  1  sys_data holds a packet byte this cycle.
REQ-006 SHALL have port sys_rx_cmd  input  8  last RX CMD (level); [1:0] LineState, [5:4] RxEvent.
REQ-007 SHALL have port out_data  output  8  packet byte at FIFO head.
REQ-008 SHALL have port out_sop  output  1  head byte is first of packet.
REQ-009 SHALL have port out_eop  output  1  head byte is last of packet.
REQ-010 SHALL have port out_err  output  1  packet had RxError or overflow; meaningful with out_eop.
REQ-011 SHALL have port out_valid  output  1  FIFO non-empty; head fields valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head when out_valid high.
REQ-013 SHALL have port line_state  output  2  registered copy of sys_rx_cmd[1:0].
REQ-014 SHALL have port ovf  output  1  sticky: an entry was dropped because FIFO full.
REQ-015 SHALL have port pkt_cnt  output  16  count of eop entries written, wraps 0xFFFF->0.

Function
REQ-016 SHALL decode rx_active = (sys_rx_cmd[5:4]==01 or 11); rx_error = (sys_rx_cmd[5:4]==11).
REQ-017 SHALL implement FSM IDLE, ACTIVE: IDLE->ACTIVE when rx_active sampled 1; ACTIVE->IDLE when rx_active sampled 0.
REQ-018 SHALL, in ACTIVE, latch rx_error into a per-packet sticky err flag, cleared on entry to ACTIVE.
REQ-019 SHALL ignore sys_data_valid in IDLE (no holding-register or FIFO change).
REQ-020 SHALL keep one holding register {byte, sop, held_valid}; first byte of a packet gets sop=1.
REQ-021 SHALL, on sys_data_valid in ACTIVE with held_valid=1, write held byte to FIFO with eop=0, err=0, then load new byte (sop=0).
REQ-022 SHALL, on sys_data_valid in ACTIVE with held_valid=0, load byte with sop=1; no FIFO write.
REQ-023 SHALL, on ACTIVE->IDLE with held_valid=1, write held byte with eop=1, err=packet err flag, clear held_valid, increment pkt_cnt.
REQ-024 SHALL, on ACTIVE->IDLE with held_valid=0 (zero-byte packet), write nothing and leave pkt_cnt unchanged.
REQ-025 SHALL perform at most one FIFO write per cycle; writes are registered at the sampling edge.
REQ-026 SHALL present FIFO head first-word-fall-through: out_valid high in the cycle after the edge that wrote an empty FIFO.
REQ-027 SHALL pop head on an edge where out_valid and out_ready are both 1.
REQ-028 SHALL, when FIFO full and no pop that edge, drop the write, set ovf, and set the packet err flag; a dropped eop entry still increments pkt_cnt.
REQ-029 SHALL accept simultaneous write and pop when full (pop frees slot; write succeeds, no ovf).
REQ-030 SHALL keep out_* stable while out_valid=1 and out_ready=0.
REQ-031 SHALL wrap FIFO read/write pointers modulo DEPTH using one extra bit for full/empty.

Reset
REQ-032 SHALL, on sys_reset, asynchronously force FSM=IDLE, FIFO empty, held_valid=0, err flag=0, ovf=0, pkt_cnt=0, line_state=0.
REQ-033 SHALL hold out_valid=0 and out_data/out_sop/out_eop/out_err=0 while FIFO empty and in reset.
REQ-034 SHALL discard any in-progress packet on reset mid-operation; no eop entry emitted for it.

Verification
REQ-035 SHALL pass: rx_cmd 0x10, bytes A5,5A,C3, rx_cmd 0x00, out_ready=1 -> A5 sop, 5A, C3 eop err=0, pkt_cnt=1.
REQ-036 SHALL pass: rx_cmd 0x10, byte 11, rx_cmd 0x30, byte 22, rx_cmd 0x00 -> 11 sop, 22 eop err=1.
REQ-037 SHALL pass: rx_cmd 0x10 then 0x00 with no bytes -> out_valid stays 0, pkt_cnt=0.
REQ-038 SHALL pass: DEPTH=4, out_ready=0, 6-byte packet -> 4 entries held, ovf=1, later drain yields err on no eop (eop dropped), pkt_cnt=1.
REQ-039 SHALL pass: single-byte packet 7E -> one entry with sop=1, eop=1.
REQ-040 SHALL pass: sys_reset pulsed after 2 bytes of a packet -> out_valid=0, pkt_cnt=0, next packet framed normally with sop on first byte.
